// File: rtl/router_fifo_param.sv
// Router packet FIFO: tagged word storage, 1-cycle registered read, packet length tracking.
// Optional occupancy/almost_full ports are built when ROUTER_FIFO_OCC_EN is defined.
module router_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  lfd_state,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  header_out,
    output logic                  full,
    output logic                  empty,
    output logic                  pkt_active,
    output logic                  wr_err
`ifdef ROUTER_FIFO_OCC_EN
    ,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [CW-1:0]         count;
    logic                  lfd_d;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  flush;
    logic [DATA_WIDTH:0]   rd_word;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign flush   = reset || soft_reset;
    assign wr_ok   = write_enb && !full;
    assign rd_ok   = read_enb && !empty;
    assign rd_word = mem[rd_ptr[AW-1:0]];

    assign pkt_active = (count != '0);

`ifdef ROUTER_FIFO_OCC_EN
    localparam logic [AW:0] AF_LVL = (AW + 1)'(AF_THRESH);

    assign occupancy   = wr_ptr - rd_ptr;
    assign almost_full = (occupancy >= AF_LVL);
`endif

    // Storage is not cleared on flush; pointers alone define contents.
    always_ff @(posedge clock) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_d, data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lfd_d      <= 1'b0;
            data_out   <= '0;
            header_out <= 1'b0;
            rd_valid   <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            lfd_d    <= lfd_state;
            wr_err   <= write_enb && full;
            rd_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (rd_ok) begin
                rd_ptr     <= rd_ptr + (AW + 1)'(1);
                data_out   <= rd_word[DATA_WIDTH-1:0];
                header_out <= rd_word[DATA_WIDTH];
                // Header carries payload length; +1 accounts for the parity word.
                if (rd_word[DATA_WIDTH]) begin
                    count <= {1'b0, rd_word[DATA_WIDTH-1:2]} + CW'(1);
                end else if (count != '0) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_router_fifo_param.sv
// Scoreboard bench for router_fifo_param: a queue model predicts read data,
// a negedge monitor compares every rd_valid word against it.
module tb_router_fifo_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       lfd_state = 1'b0;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       header_out;
    logic       full;
    logic       empty;
    logic       pkt_active;
    logic       wr_err;
`ifdef ROUTER_FIFO_OCC_EN
    logic [4:0] occupancy;
    logic       almost_full;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] mq[$];
    logic [8:0] exp_q[$];
    bit         m_lfd = 1'b0;
    bit         exp_wr_err = 1'b0;

    router_fifo_param dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .data_in    (data_in),
        .lfd_state  (lfd_state),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .header_out (header_out),
        .full       (full),
        .empty      (empty),
        .pkt_active (pkt_active),
        .wr_err     (wr_err)
`ifdef ROUTER_FIFO_OCC_EN
        ,
        .occupancy  (occupancy),
        .almost_full(almost_full)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: every presented word must match the oldest predicted read.
    always @(negedge clock) begin
        if (!reset && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid got %0h expected none",
                         {header_out, data_out});
            end else begin
                check("rd_word", {23'd0, header_out, data_out},
                      {23'd0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus; model decisions use pre-edge occupancy.
    task automatic drive(input bit we, input logic [7:0] d, input bit re,
                         input bit lfd = 1'b0, input bit sr = 1'b0,
                         input bit rst = 1'b0);
        bit wok;
        bit rok;
        write_enb  = we;
        data_in    = d;
        read_enb   = re;
        lfd_state  = lfd;
        soft_reset = sr;
        reset      = rst;
        if (rst || sr) begin
            mq.delete();
            m_lfd      = 1'b0;
            exp_wr_err = 1'b0;
        end else begin
            wok = we && (mq.size() < 16);
            rok = re && (mq.size() > 0);
            exp_wr_err = we && (mq.size() == 16);
            if (rok) exp_q.push_back(mq.pop_front());
            if (wok) mq.push_back({m_lfd, d});
            m_lfd = lfd;
        end
        @(posedge clock);
        #1;
        check("wr_err", {31'd0, wr_err}, {31'd0, exp_wr_err});
        check("empty_m", {31'd0, empty}, {31'd0, mq.size() == 0});
        check("full_m", {31'd0, full}, {31'd0, mq.size() == 16});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 8'h00, 0, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 0, 1);
        drive(0, 8'h00, 0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_pkt", {31'd0, pkt_active}, 32'd0);

        // Read on empty is ignored.
        drive(0, 8'h00, 1);
        check("empty_rd_valid", {31'd0, rd_valid}, 32'd0);

        // Fill and overflow.
        for (int i = 1; i <= 16; i++) drive(1, 8'(i), 0);
        check("fill_full", {31'd0, full}, 32'd1);
        drive(1, 8'h11, 0);
        check("ovf_err", {31'd0, wr_err}, 32'd1);
        drive(0, 8'h00, 0);
        check("ovf_err_drop", {31'd0, wr_err}, 32'd0);

        // Full: read+write performs the read only.
        drive(1, 8'h77, 1);
        check("full_rw_valid", {31'd0, rd_valid}, 32'd1);
        check("full_rw_data", {24'd0, data_out}, 32'h01);
        check("full_rw_nfull", {31'd0, full}, 32'd0);
        for (int i = 2; i <= 16; i++) begin
            drive(0, 8'h00, 1);
            check("drain_valid", {31'd0, rd_valid}, 32'd1);
        end
        check("drain_data", {24'd0, data_out}, 32'h10);
        check("drain_empty", {31'd0, empty}, 32'd1);
        drive(0, 8'h00, 0);
        check("idle_valid", {31'd0, rd_valid}, 32'd0);
        check("hold_data", {24'd0, data_out}, 32'h10);

        // Empty: read+write performs the write only.
        drive(1, 8'h3C, 1);
        check("empty_rw_valid", {31'd0, rd_valid}, 32'd0);
        check("empty_rw_nempty", {31'd0, empty}, 32'd0);
        drive(0, 8'h00, 1);
        check("empty_rw_data", {24'd0, data_out}, 32'h3C);

        // Five held: read+write keeps occupancy.
        for (int i = 0; i < 5; i++) drive(1, 8'h21 + 8'(i), 0);
        drive(1, 8'h26, 1);
        check("five_rw_data", {24'd0, data_out}, 32'h21);
`ifdef ROUTER_FIFO_OCC_EN
        check("five_occ", {27'd0, occupancy}, 32'd5);
        check("five_af", {31'd0, almost_full}, 32'd0);
`endif
        for (int i = 0; i < 5; i++) drive(0, 8'h00, 1);
        check("five_last", {24'd0, data_out}, 32'h26);

        // Packet counter: header 0x0C means 3 payload + parity = 4.
        drive(0, 8'h00, 0, 1);
        drive(1, 8'h0C, 0);
        for (int i = 0; i < 4; i++) drive(1, 8'h41 + 8'(i), 0);
        drive(0, 8'h00, 1);
        check("hdr_tag", {31'd0, header_out}, 32'd1);
        check("hdr_data", {24'd0, data_out}, 32'h0C);
        check("hdr_pkt", {31'd0, pkt_active}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 1);
            check("pay_tag", {31'd0, header_out}, 32'd0);
            check("pay_pkt", {31'd0, pkt_active}, 32'd1);
        end
        drive(0, 8'h00, 1);
        check("pkt_end", {31'd0, pkt_active}, 32'd0);

        // Wrap-around at steady 3-word occupancy.
        for (int i = 0; i < 3; i++) drive(1, 8'h50 + 8'(i), 0);
        for (int i = 0; i < 40; i++) begin
            drive(1, 8'h53 + 8'(i), 1);
            check("wrap_nempty", {31'd0, empty}, 32'd0);
            check("wrap_nfull", {31'd0, full}, 32'd0);
        end
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 1);
        check("wrap_last", {24'd0, data_out}, 32'h7A);

        // Soft reset with 7 words held mid-packet.
        drive(0, 8'h00, 0, 1);
        drive(1, 8'h1C, 0);
        for (int i = 0; i < 7; i++) drive(1, 8'h60 + 8'(i), 0);
        drive(0, 8'h00, 1);
        check("sr_pre_pkt", {31'd0, pkt_active}, 32'd1);
        drive(1, 8'hEE, 1, 0, 1);
        check("sr_empty", {31'd0, empty}, 32'd1);
        check("sr_pkt", {31'd0, pkt_active}, 32'd0);
        check("sr_data", {24'd0, data_out}, 32'd0);
        check("sr_valid", {31'd0, rd_valid}, 32'd0);
        drive(1, 8'hA5, 0);
        drive(0, 8'h00, 1);
        check("sr_a5", {24'd0, data_out}, 32'hA5);

        // Hard reset mid-packet abandons everything.
        drive(0, 8'h00, 0, 1);
        drive(1, 8'h10, 0);
        drive(1, 8'h11, 0);
        drive(1, 8'h12, 0, 0, 0, 1);
        check("rst_mid_empty", {31'd0, empty}, 32'd1);
        check("rst_mid_data", {24'd0, data_out}, 32'd0);
        drive(1, 8'h99, 0);
        drive(0, 8'h00, 1);
        check("rst_mid_99", {24'd0, data_out}, 32'h99);
        check("rst_mid_tag", {31'd0, header_out}, 32'd0);
        drive(0, 8'h00, 0);

        check("exp_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fifo_param.md
ROUTER_FIFO_PARAM -- requirements
Module: router_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per word, legal range >=4.
REQ-002 SHALL have parameter DEPTH, default 16: number of words, power of two, >=4; AW = log2(DEPTH).
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full threshold in words, legal range 1..DEPTH.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clock, input, 1: rising-edge clock for all state.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port soft_reset, input, 1: synchronous flush from the router controller's timeout logic.
REQ-008 SHALL have ports write_enb, input, 1 and data_in, input, DATA_WIDTH: write request and write word.
REQ-009 SHALL have port lfd_state, input, 1: high in the cycle before the header word is written.
REQ-010 SHALL have port read_enb, input, 1: read request.
REQ-011 SHALL have ports data_out, output, DATA_WIDTH and rd_valid, output, 1: registered read data and its qualifier.
REQ-012 SHALL have port header_out, output, 1: header tag of the word currently on data_out.
REQ-013 SHALL have ports full, output, 1 and empty, output, 1: combinational status flags.
REQ-014 SHALL have port pkt_active, output, 1: high while the packet read counter is nonzero.
REQ-015 SHALL have port wr_err, output, 1: one-cycle pulse on a rejected write.

Function
REQ-016 SHALL store DATA_WIDTH+1 bits per entry; the tag bit SHALL equal lfd_state registered one cycle (lfd_d).
REQ-017 SHALL use AW+1-bit wr_ptr and rd_ptr; empty = (wr_ptr == rd_ptr); full = (MSBs differ and AW LSBs equal).
REQ-018 SHALL accept a write when write_enb and !full: store the word and tag at wr_ptr[AW-1:0], then increment wr_ptr modulo 2^(AW+1).
REQ-019 SHALL accept a read when read_enb and !empty: load data_out and header_out next edge (1-cycle latency), assert rd_valid for that cycle only, then increment rd_ptr.
REQ-020 SHALL hold data_out and header_out when no read is accepted, and SHALL deassert rd_valid in that case.
REQ-021 SHALL evaluate full and empty before the edge when read and write coincide: full -> read only, empty -> write only, otherwise both accepted and occupancy unchanged.
REQ-022 SHALL pulse wr_err for one cycle on write_enb && full; memory and pointers SHALL be unchanged.
REQ-023 SHALL ignore read_enb when empty, with no pointer change and no error.
REQ-024 SHALL implement the packet counter as a (DATA_WIDTH-1)-bit count with the following rule per accepted read:
- tagged word: count = word[DATA_WIDTH-1:2] + 1 (payload length + parity);
- untagged word and count != 0: count = count - 1;
- otherwise: count unchanged.
REQ-025 SHALL drive pkt_active = (count != 0).
REQ-026 SHALL apply soft_reset (when reset is low) in one cycle: pointers, count, data_out, header_out, rd_valid, wr_err and lfd_d to 0; memory contents need not be cleared; requests in that cycle are ignored.
REQ-027 SHALL give reset priority over soft_reset.

Reset
REQ-028 SHALL on reset drive: wr_ptr=0, rd_ptr=0, count=0, lfd_d=0, data_out=0, header_out=0, rd_valid=0, wr_err=0; hence empty=1, full=0, pkt_active=0.
REQ-029 SHALL, when reset is asserted mid-packet, abandon the packet with no residual state; the first write after reset lands at entry 0.

Configuration
REQ-030 SHALL provide macro ROUTER_FIFO_OCC_EN; when defined, the following ports SHALL exist:
- occupancy, output, AW+1: equal to wr_ptr - rd_ptr;
- almost_full, output, 1: equal to (occupancy >= AF_THRESH).
REQ-031 SHALL, when ROUTER_FIFO_OCC_EN is undefined, omit both ports and their logic, with all other behaviour identical.

Verification
REQ-032 SHALL cover reset: after reset, empty=1, full=0, data_out=0, pkt_active=0; a read on the empty FIFO produces rd_valid=0.
REQ-033 SHALL cover fill and overflow (defaults): write 0x01..0x10 -> full=1 after the 16th write; a 17th write -> wr_err=1 for one cycle; read back 0x01..0x10 in order with rd_valid each cycle -> empty=1.
REQ-034 SHALL cover the packet counter: lfd_state=1 then write header 0x0C plus 4 words -> reading the header gives header_out=1 and count=4; pkt_active falls after the 4th following read.
REQ-035 SHALL cover simultaneous access: with 16 words held, read+write -> read only; with 0 words, read+write -> write only, empty=0 next cycle; with 5 words, read+write -> occupancy stays 5 (OCC_EN).
REQ-036 SHALL cover wrap-around: perform 40 writes/reads interleaved at 3-word occupancy -> data order preserved through pointer wrap, and neither full nor empty asserts spuriously.
REQ-037 SHALL cover soft_reset: assert soft_reset with 7 words held mid-packet -> next cycle empty=1, pkt_active=0, data_out=0; a subsequent write of 0xA5 reads back as 0xA5.
